// File: rtl/sram_resp_model_pkg.sv
// ---------------------------------------------------------------------------
// sram_resp_pkg
//   Shared types, defaults and the address-decode helper for sram_resp_model.
//
//   DEFAULT_BASE_ADDR : byte address that maps to RAM word 0
//   DEFAULT_ADDR_W    : word-index width (RAM depth = 2**ADDR_W words)
//   RD_LAT_MAX        : deepest supported read-latency pipe
//   decode_t          : {ok, idx} result of in_range()
//   in_range()        : wrapping subtract against the base, range test and
//                       word index extraction
// ---------------------------------------------------------------------------
package sram_resp_pkg;

  localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h1c00_0000;
  localparam int          DEFAULT_ADDR_W    = 16;
  localparam int          RD_LAT_MAX        = 4;

  // idx carries the full 30-bit word offset; the caller keeps the low ADDR_W
  // bits. ok is only true when every bit above the RAM window is zero.
  typedef struct packed {
    logic        ok;
    logic [29:0] idx;
  } decode_t;

  // addr_w must be at most 30. The subtract wraps, so an address just below
  // the base produces a huge offset and is correctly reported out of range.
  function automatic decode_t in_range(
    input logic [31:0] addr,
    input logic [31:0] base,
    input int unsigned addr_w
  );
    logic [31:0] off;
    decode_t     res;
    off     = addr - base;
    res.ok  = ((off >> (addr_w + 2)) == 32'd0);
    res.idx = off[31:2];
    return res;
  endfunction

endpackage : sram_resp_pkg

// File: rtl/sram_resp_model_if.sv
// ---------------------------------------------------------------------------
// sram_resp_model_if
//   Bundles the CPU's instruction and data SRAM ports. There is no handshake:
//   the responder samples both ports every cycle.
//
//   inst_sram_we / addr / wdata : inst port request (write is illegal)
//   inst_sram_rdata             : inst read data
//   data_sram_we / addr / wdata : data port request
//   data_sram_rdata             : data read data
//
//   master : CPU side (drives requests, receives rdata)
//   slave  : memory side (sram_resp_model)
// ---------------------------------------------------------------------------
interface sram_resp_model_if;

  logic        inst_sram_we;
  logic [31:0] inst_sram_addr;
  logic [31:0] inst_sram_wdata;
  logic [31:0] inst_sram_rdata;

  logic        data_sram_we;
  logic [31:0] data_sram_addr;
  logic [31:0] data_sram_wdata;
  logic [31:0] data_sram_rdata;

  modport master (
    output inst_sram_we, inst_sram_addr, inst_sram_wdata,
    input  inst_sram_rdata,
    output data_sram_we, data_sram_addr, data_sram_wdata,
    input  data_sram_rdata
  );

  modport slave (
    input  inst_sram_we, inst_sram_addr, inst_sram_wdata,
    output inst_sram_rdata,
    input  data_sram_we, data_sram_addr, data_sram_wdata,
    output data_sram_rdata
  );

endinterface : sram_resp_model_if

// File: rtl/sram_resp_model_rd_lat_pipe.sv
// ---------------------------------------------------------------------------
// rd_lat_pipe
//   Fixed-depth registered delay line with asynchronous active-high reset.
//   d is captured into stage 0 every edge; q is the last stage, so a value
//   presented at cycle N is visible on q from cycle N+DEPTH onward.
//
//   clk   : clock
//   reset : asynchronous, active-high; clears every stage immediately
//   d     : input word (W bits)
//   q     : delayed output word (W bits), registered
// ---------------------------------------------------------------------------
module rd_lat_pipe #(
  parameter int W     = 32,
  parameter int DEPTH = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [DEPTH-1:0][W-1:0] stage_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stage_reg <= '0;
    end else begin
      stage_reg[0] <= d;
      for (int i = 1; i < DEPTH; i++) begin
        stage_reg[i] <= stage_reg[i-1];
      end
    end
  end

  assign q = stage_reg[DEPTH-1];

endmodule : rd_lat_pipe

// File: rtl/sram_resp_model.sv
// ---------------------------------------------------------------------------
// sram_resp_model
//   Responder for the CPU's inst/data SRAM ports. One shared, word-addressed
//   RAM; the inst port only reads, the data port reads and writes. Read data
//   appears RD_LAT cycles after the address and holds until replaced.
//
//   Parameters
//     BASE_ADDR : byte address mapped to RAM word 0
//     ADDR_W    : word-index width, RAM depth = 2**ADDR_W words (<= 30)
//     RD_LAT    : read latency in cycles, 1..RD_LAT_MAX
//
//   Ports
//     clk         : clock, all logic on posedge
//     reset       : asynchronous, active-high
//     bus         : sram_resp_model_if.slave (inst + data SRAM ports)
//     err_sticky  : out-of-range access or inst-port write seen since reset
//     inst_rd_cnt : cycles with an in-range inst address (wraps)
//     data_wr_cnt : accepted data writes (wraps)
//
//   RAM contents are not reset; simulation may preload them.
// ---------------------------------------------------------------------------
module sram_resp_model
  import sram_resp_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = DEFAULT_BASE_ADDR,
  parameter int          ADDR_W    = DEFAULT_ADDR_W,
  parameter int          RD_LAT    = 1
) (
  input  logic              clk,
  input  logic              reset,
  sram_resp_model_if.slave  bus,
  output logic              err_sticky,
  output logic [31:0]       inst_rd_cnt,
  output logic [31:0]       data_wr_cnt
);

  localparam int RAM_WORDS = 2 ** ADDR_W;

  generate
    if (RD_LAT < 1 || RD_LAT > RD_LAT_MAX) begin : g_bad_rd_lat
      $error("sram_resp_model: RD_LAT=%0d outside 1..%0d", RD_LAT, RD_LAT_MAX);
    end
  endgenerate

  // -------------------------------------------------------------------------
  // Address decode
  // -------------------------------------------------------------------------
  decode_t           inst_dec;
  decode_t           data_dec;
  logic [ADDR_W-1:0] inst_idx;
  logic [ADDR_W-1:0] data_idx;

  assign inst_dec = in_range(bus.inst_sram_addr, BASE_ADDR, ADDR_W);
  assign data_dec = in_range(bus.data_sram_addr, BASE_ADDR, ADDR_W);
  assign inst_idx = inst_dec.idx[ADDR_W-1:0];
  assign data_idx = data_dec.idx[ADDR_W-1:0];

  // Bits that carry no function here: the upper word-offset bits are already
  // folded into .ok, and the inst port has no write path.
  logic unused_bits;
  assign unused_bits = ^{inst_dec.idx, data_dec.idx, bus.inst_sram_wdata};

  // -------------------------------------------------------------------------
  // RAM and write path
  // -------------------------------------------------------------------------
  logic [31:0] mem [RAM_WORDS];
  logic        data_wr_en;

  // A write presented while reset is high is dropped, so the RAM port is
  // gated by reset even though the RAM itself has no reset.
  assign data_wr_en = bus.data_sram_we && data_dec.ok && !reset;

  always_ff @(posedge clk) begin
    if (data_wr_en) begin
      mem[data_idx] <= bus.data_sram_wdata;
    end
  end

  // -------------------------------------------------------------------------
  // Read capture with write-first bypass
  //   Out-of-range reads feed zero into the pipe. A same-cycle data write to
  //   the word being read is forwarded so both ports see the new value. The
  //   data port reads and writes the same address, so any accepted write is
  //   a hit for it.
  // -------------------------------------------------------------------------
  logic [31:0] inst_rd_next;
  logic [31:0] data_rd_next;

  always_comb begin
    inst_rd_next = 32'h0;
    if (inst_dec.ok) begin
      if (data_wr_en && (data_idx == inst_idx)) begin
        inst_rd_next = bus.data_sram_wdata;
      end else begin
        inst_rd_next = mem[inst_idx];
      end
    end
  end

  always_comb begin
    data_rd_next = 32'h0;
    if (data_dec.ok) begin
      if (data_wr_en) begin
        data_rd_next = bus.data_sram_wdata;
      end else begin
        data_rd_next = mem[data_idx];
      end
    end
  end

  // -------------------------------------------------------------------------
  // Latency pipes: the last stage register drives rdata directly.
  // -------------------------------------------------------------------------
  rd_lat_pipe #(
    .W     (32),
    .DEPTH (RD_LAT)
  ) u_inst_pipe (
    .clk   (clk),
    .reset (reset),
    .d     (inst_rd_next),
    .q     (bus.inst_sram_rdata)
  );

  rd_lat_pipe #(
    .W     (32),
    .DEPTH (RD_LAT)
  ) u_data_pipe (
    .clk   (clk),
    .reset (reset),
    .d     (data_rd_next),
    .q     (bus.data_sram_rdata)
  );

  // -------------------------------------------------------------------------
  // Error flag and activity counters
  // -------------------------------------------------------------------------
  logic err_set;

  assign err_set = bus.inst_sram_we || !inst_dec.ok || !data_dec.ok;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_sticky  <= 1'b0;
      inst_rd_cnt <= 32'h0;
      data_wr_cnt <= 32'h0;
    end else begin
      if (err_set) begin
        err_sticky <= 1'b1;
      end
      // Both counters wrap naturally at 32 bits.
      if (inst_dec.ok) begin
        inst_rd_cnt <= inst_rd_cnt + 32'd1;
      end
      if (data_wr_en) begin
        data_wr_cnt <= data_wr_cnt + 32'd1;
      end
    end
  end

endmodule : sram_resp_model

// File: tb/tb_sram_resp_model.sv
// ---------------------------------------------------------------------------
// tb_sram_resp_model
//   Drives identical traffic into two responders (RD_LAT = 1 and RD_LAT = 3)
//   and checks rdata through per-port expectation queues fed by a reference
//   memory model, plus the sticky flag and both counters every cycle.
// ---------------------------------------------------------------------------
module tb_sram_resp_model;

  localparam logic [31:0] BASE = 32'h1c00_0000;
  localparam logic [31:0] SPAN = 32'h0004_0000;  // 4 * 2**16 bytes
  localparam logic [31:0] A0   = 32'h1c00_0000;
  localparam logic [31:0] A1   = 32'h1c00_0010;
  localparam logic [31:0] A2   = 32'h1c00_0020;

  typedef struct {
    logic [31:0] val;
    bit          chk;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b0;

  logic        err1, err3;
  logic [31:0] ird1, ird3, wr1, wr3;

  sram_resp_model_if bus1 ();
  sram_resp_model_if bus3 ();

  sram_resp_model #(.RD_LAT(1)) u_dut1 (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus1),
    .err_sticky  (err1),
    .inst_rd_cnt (ird1),
    .data_wr_cnt (wr1)
  );

  sram_resp_model #(.RD_LAT(3)) u_dut3 (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus3),
    .err_sticky  (err3),
    .inst_rd_cnt (ird3),
    .data_wr_cnt (wr3)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // reference model
  logic [31:0] mem_m [int unsigned];
  logic        err_m;
  logic [31:0] ird_cnt_m;
  logic [31:0] wr_cnt_m;
  exp_t q_i1[$];
  exp_t q_d1[$];
  exp_t q_i3[$];
  exp_t q_d3[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  function automatic bit addr_ok(input logic [31:0] a);
    return (a >= BASE) && (a < BASE + SPAN);
  endfunction

  function automatic int unsigned word_idx(input logic [31:0] a);
    return int'((a - BASE) >> 2);
  endfunction

  function automatic exp_t exp_rd(input logic [31:0] a, input bit wr_ok,
                                  input int unsigned widx, input logic [31:0] wdata);
    exp_t e;
    e.val = 32'h0;
    e.chk = 1'b1;
    if (addr_ok(a)) begin
      if (wr_ok && (widx == word_idx(a))) begin
        e.val = wdata;
      end else if (mem_m.exists(word_idx(a))) begin
        e.val = mem_m[word_idx(a)];
      end else begin
        e.chk = 1'b0;  // never-written word: contents unknown
      end
    end
    return e;
  endfunction

  task automatic drive(input logic iwe, input logic [31:0] iaddr,
                       input logic dwe, input logic [31:0] daddr, input logic [31:0] dwdata);
    bus1.inst_sram_we    = iwe;
    bus1.inst_sram_addr  = iaddr;
    bus1.inst_sram_wdata = 32'h0;
    bus1.data_sram_we    = dwe;
    bus1.data_sram_addr  = daddr;
    bus1.data_sram_wdata = dwdata;
    bus3.inst_sram_we    = iwe;
    bus3.inst_sram_addr  = iaddr;
    bus3.inst_sram_wdata = 32'h0;
    bus3.data_sram_we    = dwe;
    bus3.data_sram_addr  = daddr;
    bus3.data_sram_wdata = dwdata;
  endtask

  task automatic check_status(input string tag);
    check({tag, "/err1"}, {31'h0, err1}, {31'h0, err_m});
    check({tag, "/err3"}, {31'h0, err3}, {31'h0, err_m});
    check({tag, "/ird1"}, ird1, ird_cnt_m);
    check({tag, "/ird3"}, ird3, ird_cnt_m);
    check({tag, "/wr1"},  wr1,  wr_cnt_m);
    check({tag, "/wr3"},  wr3,  wr_cnt_m);
  endtask

  // One clock of traffic: predict, push, clock, pop and compare.
  task automatic step(input string tag, input logic iwe, input logic [31:0] iaddr,
                      input logic dwe, input logic [31:0] daddr, input logic [31:0] dwdata);
    bit          wr_ok;
    int unsigned widx;
    exp_t        ei, ed, e;
    drive(iwe, iaddr, dwe, daddr, dwdata);
    wr_ok = dwe && addr_ok(daddr);
    widx  = word_idx(daddr);
    ei = exp_rd(iaddr, wr_ok, widx, dwdata);
    ed = exp_rd(daddr, wr_ok, widx, dwdata);
    q_i1.push_back(ei);
    q_i3.push_back(ei);
    q_d1.push_back(ed);
    q_d3.push_back(ed);
    if (wr_ok) begin
      mem_m[widx] = dwdata;
      wr_cnt_m++;
    end
    if (addr_ok(iaddr)) ird_cnt_m++;
    if (iwe || !addr_ok(iaddr) || !addr_ok(daddr)) err_m = 1'b1;
    @(posedge clk);
    #1;
    e = q_i1.pop_front();
    if (e.chk) check({tag, "/inst1"}, bus1.inst_sram_rdata, e.val);
    e = q_d1.pop_front();
    if (e.chk) check({tag, "/data1"}, bus1.data_sram_rdata, e.val);
    e = q_i3.pop_front();
    if (e.chk) check({tag, "/inst3"}, bus3.inst_sram_rdata, e.val);
    e = q_d3.pop_front();
    if (e.chk) check({tag, "/data3"}, bus3.data_sram_rdata, e.val);
    check_status(tag);
    $display("step %-12s iwe=%0b ia=%08h dwe=%0b da=%08h dw=%08h | i1=%08h d1=%08h i3=%08h d3=%08h err=%0b",
             tag, iwe, iaddr, dwe, daddr, dwdata, bus1.inst_sram_rdata, bus1.data_sram_rdata,
             bus3.inst_sram_rdata, bus3.data_sram_rdata, err1);
  endtask

  task automatic idle(input string tag, input int n);
    for (int i = 0; i < n; i++) step(tag, 1'b0, A0, 1'b0, A0, 32'h0);
  endtask

  // Assert reset (the pipe must clear at once), hold it for some edges while
  // driving the given data request (which must be dropped), then release.
  task automatic do_reset(input string tag, input int cycles, input logic dwe,
                          input logic [31:0] daddr, input logic [31:0] dwdata);
    exp_t z;
    z.val = 32'h0;
    z.chk = 1'b1;
    drive(1'b0, A0, dwe, daddr, dwdata);
    reset = 1'b1;
    #1;
    check({tag, "/inst1"}, bus1.inst_sram_rdata, 32'h0);
    check({tag, "/data1"}, bus1.data_sram_rdata, 32'h0);
    check({tag, "/inst3"}, bus3.inst_sram_rdata, 32'h0);
    check({tag, "/data3"}, bus3.data_sram_rdata, 32'h0);
    err_m     = 1'b0;
    ird_cnt_m = 32'h0;
    wr_cnt_m  = 32'h0;
    check_status(tag);
    repeat (cycles) @(posedge clk);
    #1;
    reset = 1'b0;
    q_i1.delete();
    q_d1.delete();
    q_i3.delete();
    q_d3.delete();
    repeat (2) begin
      q_i3.push_back(z);
      q_d3.push_back(z);
    end
    drive(1'b0, A0, 1'b0, A0, 32'h0);
    $display("reset %-11s held %0d cycles, dwe=%0b da=%08h dw=%08h", tag, cycles, dwe, daddr, dwdata);
  endtask

  initial begin
    err_m     = 1'b0;
    ird_cnt_m = 32'h0;
    wr_cnt_m  = 32'h0;
    drive(1'b0, A0, 1'b0, A0, 32'h0);
    #2;
    do_reset("por", 2, 1'b0, A0, 32'h0);

    // Load word 0 through the data port, then reset: RAM survives reset.
    step("preload", 1'b0, A0, 1'b1, A0, 32'h0280_0421);
    do_reset("rst_keep", 2, 1'b0, A0, 32'h0);

    // 1: inst fetch of preloaded word, zero before latency expires
    step("t1_fetch", 1'b0, A0, 1'b0, A0, 32'h0);
    idle("t1_drain", 3);

    // 2: write then read back
    step("t2_wr", 1'b0, A0, 1'b1, A1, 32'hdead_beef);
    step("t2_rd", 1'b0, A0, 1'b0, A1, 32'h0);
    idle("t2_drain", 3);
    check("t2_wrcnt1", wr1, 32'd1);
    check("t2_wrcnt3", wr3, 32'd1);

    // 3: same-cycle write and inst read of one word (write-first)
    step("t3_coll", 1'b0, A2, 1'b1, A2, 32'h1234_5678);
    idle("t3_drain", 3);

    // 4: out-of-range read below base, dropped write above the window
    step("t4_rd_lo", 1'b0, A0, 1'b0, 32'h1bff_fffc, 32'h0);
    step("t4_wr_hi", 1'b0, A0, 1'b1, BASE + SPAN, 32'hffff_ffff);
    step("t4_rd_w0", 1'b0, A0, 1'b0, A0, 32'h0);
    step("t4_i_hi", 1'b0, BASE + SPAN, 1'b0, A1, 32'h0);
    idle("t4_drain", 3);
    check("t4_err1", {31'h0, err1}, 32'd1);
    check("t4_err3", {31'h0, err3}, 32'd1);
    check("t4_wrcnt1", wr1, 32'd2);
    check("t4_wrcnt3", wr3, 32'd2);

    // 5: back-to-back addresses through the pipe
    step("t5_a0", 1'b0, A0, 1'b0, A0, 32'h0);
    step("t5_a1", 1'b0, A1, 1'b0, A1, 32'h0);
    step("t5_a2", 1'b0, A2, 1'b0, A2, 32'h0);
    idle("t5_drain", 3);

    // 6: reset with reads in flight, write during reset is dropped
    step("t6_a1", 1'b0, A1, 1'b0, A1, 32'h0);
    step("t6_a2", 1'b0, A2, 1'b0, A2, 32'h0);
    do_reset("t6_rst", 2, 1'b1, A1, 32'hbad0_bad0);
    step("t6_rd_a1", 1'b0, A1, 1'b0, A1, 32'h0);
    idle("t6_drain", 3);

    // inst-port write attempt: ignored, but flags the error
    step("iwe", 1'b1, A0, 1'b0, A0, 32'h0);
    idle("iwe_drain", 3);
    check("iwe_err1", {31'h0, err1}, 32'd1);
    check("iwe_err3", {31'h0, err3}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_sram_resp_model
